// File: rtl/icache_pkg.sv
// Shared definitions for the icache line-fill path.
// Holds default geometry, the derived line/beat/tag sizes, the fill FSM state
// type and the tag type. Modules take the defaults from here and can override
// them through their own parameters.
package icache_pkg;

   localparam int unsigned S_INDEX  = 3;
   localparam int unsigned S_OFFSET = 5;
   localparam int unsigned S_BEAT   = 64;
   localparam int unsigned NUM_WAYS = 2;

   localparam int unsigned LINE_BITS = (2 ** S_OFFSET) * 8;
   localparam int unsigned BEATS     = LINE_BITS / S_BEAT;
   localparam int unsigned TAG_W     = 32 - S_INDEX - S_OFFSET;

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} fill_state_t;

   typedef logic [TAG_W-1:0] tag_t;

   // Line width in bits for a given offset width.
   function automatic int unsigned line_bits(input int unsigned off);
      return (2 ** off) * 8;
   endfunction

endpackage

// File: rtl/line_assembler.sv
// Beat counter plus line register for a pmem burst.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          restart assembly at beat 0 (line contents kept)
//   beat_valid   beat_data is a beat to store at the current slot
//   beat_data    one burst beat
//   last         beat_valid on the final slot of the line
//   line         assembled line, beat 0 in the lowest bits
module line_assembler #(
   parameter int unsigned LineBits = 256,
   parameter int unsigned BeatW    = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                beat_valid,
   input  logic [BeatW-1:0]    beat_data,
   output logic                last,
   output logic [LineBits-1:0] line
);

   localparam int unsigned Beats = LineBits / BeatW;
   localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Beats - 1);

   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [LineBits-1:0] line_q, line_d;

   always_comb begin
      cnt_d  = cnt_q;
      line_d = line_q;
      if (clr) begin
         cnt_d = '0;
      end else if (beat_valid) begin
         for (int i = 0; i < int'(Beats); i++) begin
            if (cnt_q == CntW'(i)) begin
               line_d[i*BeatW +: BeatW] = beat_data;
            end
         end
         // Wrap on the last beat so the counter never exceeds Beats-1.
         cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         line_q <= line_d;
      end
   end

   assign last = beat_valid && (cnt_q == CntLast);
   assign line = line_q;

endmodule

// File: rtl/icache_line_fill.sv
// Icache line fill: on a miss, bursts one line from pmem, assembles it and
// writes data/tag/valid into the victim way in a single cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   miss_req, miss_addr      fill request (held until fill_done) and address
//   victim_way               way to replace, sampled on accept
//   pmem_rdata, pmem_resp    burst beat data / valid
//   pmem_read, pmem_address  burst request and line-aligned address
//   busy                     fill in progress
//   fill_done                one-cycle pulse after the array write
//   way_load                 one-hot array load strobe
//   windex, tag_out, line_out  array write index, tag and line
module icache_line_fill
   import icache_pkg::*;
#(
   parameter int unsigned s_index  = S_INDEX,
   parameter int unsigned s_offset = S_OFFSET,
   parameter int unsigned s_beat   = S_BEAT,
   parameter int unsigned num_ways = NUM_WAYS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_req,
   input  logic [31:0]                  miss_addr,
   input  logic [$clog2(num_ways)-1:0]  victim_way,
   input  logic [s_beat-1:0]            pmem_rdata,
   input  logic                         pmem_resp,
   output logic                         pmem_read,
   output logic [31:0]                  pmem_address,
   output logic                         busy,
   output logic                         fill_done,
   output logic [num_ways-1:0]          way_load,
   output logic [s_index-1:0]           windex,
   output logic [31-s_index-s_offset:0] tag_out,
   output logic [2**s_offset*8-1:0]     line_out
);

   localparam int unsigned LineBits = line_bits(s_offset);
   localparam int unsigned TagW     = 32 - s_index - s_offset;
   localparam logic [31:0] OffMask  = (32'd1 << s_offset) - 32'd1;

   fill_state_t                 state_q, state_d;
   logic [31:0]                 addr_q, addr_d;
   logic [$clog2(num_ways)-1:0] way_q, way_d;

   logic accept;
   logic beat_valid;
   logic beat_last;

   // fill_done only rises in DONE, so a request still held there cannot retrigger.
   assign accept     = (state_q == IDLE) && miss_req && !fill_done;
   assign beat_valid = pmem_resp && (state_q == FETCH);

   line_assembler #(
      .LineBits (LineBits),
      .BeatW    (s_beat)
   ) u_line_assembler (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept),
      .beat_valid (beat_valid),
      .beat_data  (pmem_rdata),
      .last       (beat_last),
      .line       (line_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         way_q   <= way_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      way_d   = way_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = FETCH;
               addr_d  = miss_addr & ~OffMask;
               way_d   = victim_way;
            end
         end
         FETCH:   if (beat_last) state_d = WRITE;
         WRITE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pmem_read = 1'b0;
      busy      = 1'b1;
      fill_done = 1'b0;
      way_load  = '0;
      unique case (state_q)
         IDLE:    busy = 1'b0;
         FETCH:   pmem_read = 1'b1;
         WRITE:   way_load[way_q] = 1'b1;
         DONE:    fill_done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Address-derived outputs come straight from the latched address, so they
   // stay stable from WRITE until the next accept.
   assign pmem_address = addr_q;
   assign windex       = addr_q[s_offset +: s_index];
   assign tag_out      = addr_q[31 -: TagW];

endmodule

// File: tb/tb_icache_line_fill.sv
`timescale 1ns/1ps
module tb_icache_line_fill;

   localparam int NB = 4;

   logic         clk        = 1'b0;
   logic         rst        = 1'b0;
   logic         miss_req   = 1'b0;
   logic [31:0]  miss_addr  = '0;
   logic [0:0]   victim_way = '0;
   logic [63:0]  pmem_rdata = '0;
   logic         pmem_resp  = 1'b0;
   logic         pmem_read;
   logic [31:0]  pmem_address;
   logic         busy;
   logic         fill_done;
   logic [1:0]   way_load;
   logic [2:0]   windex;
   logic [23:0]  tag_out;
   logic [255:0] line_out;

   always #5 clk = ~clk;

   icache_line_fill dut (
      .clk          (clk),
      .rst          (rst),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .victim_way   (victim_way),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .pmem_read    (pmem_read),
      .pmem_address (pmem_address),
      .busy         (busy),
      .fill_done    (fill_done),
      .way_load     (way_load),
      .windex       (windex),
      .tag_out      (tag_out),
      .line_out     (line_out)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Transaction-level model: an active fill, beats received so far, and how
   // many cycles have passed since the last beat (1 = array write, 2 = done).
   bit          m_active;
   int          m_got;
   int          m_post;
   logic [31:0] m_addr;
   int          m_way;
   logic [63:0] m_beat [NB];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active <= 1'b0;
         m_got    <= 0;
         m_post   <= 0;
         m_addr   <= '0;
         m_way    <= 0;
         for (int i = 0; i < NB; i++) m_beat[i] <= '0;
      end else if (!m_active) begin
         if (miss_req) begin
            m_active <= 1'b1;
            m_addr   <= miss_addr - (miss_addr % 32);
            m_way    <= int'(victim_way);
            m_got    <= 0;
            m_post   <= 0;
         end
      end else if (m_got < NB) begin
         if (pmem_resp) begin
            m_beat[m_got] <= pmem_rdata;
            m_got         <= m_got + 1;
            if (m_got == NB - 1) m_post <= 1;
         end
      end else if (m_post == 1) begin
         m_post <= 2;
      end else begin
         m_active <= 1'b0;
         m_post   <= 0;
      end
   end

   logic [255:0] exp_line;

   always @(negedge clk) begin
      exp_line = '0;
      for (int i = 0; i < NB; i++) exp_line[i*64 +: 64] = m_beat[i];
      check("busy", busy, m_active);
      check("pmem_read", pmem_read, m_active && (m_got < NB));
      check("pmem_address", pmem_address, m_addr);
      check("fill_done", fill_done, m_post == 2);
      check("way_load", way_load, (m_post == 1) ? (256'(1) << m_way) : 256'(0));
      check("windex", windex, (m_addr / 32) % 8);
      check("tag_out", tag_out, m_addr / 256);
      check("line_out", line_out, exp_line);
   end

   // Monitor: burst count, array-write captures, address seen during a burst.
   int           bursts    = 0;
   int           wl_events = 0;
   logic         prev_read = 1'b0;
   logic [255:0] cap_line  = '0;
   logic [1:0]   cap_wl    = '0;
   logic [2:0]   cap_idx   = '0;
   logic [23:0]  cap_tag   = '0;
   logic [31:0]  cap_paddr = '0;

   always @(negedge clk) begin
      if (pmem_read && !prev_read) bursts <= bursts + 1;
      prev_read <= pmem_read;
      if (way_load != 2'b00) begin
         wl_events <= wl_events + 1;
         cap_line  <= line_out;
         cap_wl    <= way_load;
         cap_idx   <= windex;
         cap_tag   <= tag_out;
      end
      if (pmem_read) cap_paddr <= pmem_address;
   end

   logic [63:0] beat_tab [NB];
   int          gap_tab  [NB];
   int          last_lat;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [255:0] tab_line();
      logic [255:0] l;
      l = '0;
      for (int i = 0; i < NB; i++) l[i*64 +: 64] = beat_tab[i];
      return l;
   endfunction

   // Issue one fill and play the pmem side: first beat one cycle after
   // pmem_read rises, gap_tab[b] stall cycles before beat b.
   task automatic do_fill(input logic [31:0] addr, input logic way, input bit hold,
                          input bit spur);
      int n;
      int acc;
      n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      check("idle_before_fill", busy, 1'b0);
      miss_req   = 1'b1;
      miss_addr  = addr;
      victim_way = way;
      acc        = cyc;
      n          = 0;
      do begin
         tick();
         n++;
         if (!hold) begin
            miss_req   = 1'b0;
            miss_addr  = $urandom;
            victim_way = 1'($urandom);
         end
      end while (!pmem_read && n < 10);
      check("read_rise_wait", pmem_read, 1'b1);
      for (int b = 0; b < NB; b++) begin
         if (b > 0) begin
            for (int g = 0; g < gap_tab[b]; g++) begin
               tick();
               pmem_resp  = 1'b0;
               pmem_rdata = {$urandom, $urandom};
            end
         end
         tick();
         pmem_resp  = 1'b1;
         pmem_rdata = beat_tab[b];
      end
      tick();
      pmem_resp  = spur;
      pmem_rdata = 64'hDEAD;
      n = 0;
      while (!fill_done && n < 20) begin
         tick();
         n++;
      end
      check("fill_done_wait", fill_done, 1'b1);
      last_lat = cyc - acc;
      tick();
      pmem_resp = 1'b0;
      miss_req  = 1'b0;
   endtask

   localparam logic [255:0] BasicLine = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

   int b0;
   int w0;
   int n;
   int gsum;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", busy, 1'b0);
      check("reset_read", pmem_read, 1'b0);
      check("reset_line", line_out, 256'd0);
      rst = 1'b1;
      tick();

      // Basic fill with the request held through fill_done.
      beat_tab = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      gap_tab  = '{0, 0, 0, 0};
      b0 = bursts;
      do_fill(32'h0000_1A64, 1'b1, 1'b1, 1'b0);
      check("basic_latency", last_lat, 7);
      check("basic_paddr", cap_paddr, 32'h0000_1A60);
      check("basic_way_load", cap_wl, 2'b10);
      check("basic_windex", cap_idx, 3'd3);
      check("basic_tag", cap_tag, 24'h00001A);
      check("basic_line", cap_line, BasicLine);
      check("held_one_burst", bursts - b0, 1);
      tick();
      // Second request two cycles after fill_done.
      do_fill(32'h0000_1A64, 1'b0, 1'b1, 1'b0);
      check("held_second_burst", bursts - b0, 2);
      check("second_way_load", cap_wl, 2'b01);

      // Stalled burst.
      gap_tab = '{0, 2, 3, 0};
      do_fill(32'h0000_1A64, 1'b1, 1'b0, 1'b0);
      check("stall_latency", last_lat, 12);
      check("stall_line", cap_line, BasicLine);

      // Spurious responses in IDLE, then in WRITE/DONE.
      gap_tab   = '{0, 0, 0, 0};
      pmem_resp = 1'b1;
      pmem_rdata = 64'hDEAD;
      tick();
      tick();
      pmem_resp = 1'b0;
      check("spur_idle_line", line_out, BasicLine);
      check("spur_idle_busy", busy, 1'b0);
      check("spur_idle_way_load", way_load, 2'b00);
      do_fill(32'h0000_1A64, 1'b1, 1'b0, 1'b1);
      check("spur_done_line", line_out, BasicLine);
      check("spur_done_way_load", way_load, 2'b00);

      // Reset after two beats.
      w0         = wl_events;
      miss_req   = 1'b1;
      miss_addr  = 32'h0000_2F40;
      victim_way = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!pmem_read && n < 10);
      miss_req = 1'b0;
      check("rst_mid_read_rise", pmem_read, 1'b1);
      tick();
      pmem_resp  = 1'b1;
      pmem_rdata = 64'hAAAA_0000_0000_0001;
      tick();
      pmem_rdata = 64'hAAAA_0000_0000_0002;
      tick();
      pmem_resp = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_mid_read", pmem_read, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_way_load", way_load, 2'b00);
      tick();
      tick();
      rst = 1'b1;
      check("rst_no_write", wl_events - w0, 0);
      beat_tab = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
      do_fill(32'h0000_2F5C, 1'b0, 1'b1, 1'b0);
      check("rst_refill_way_load", cap_wl, 2'b01);
      check("rst_refill_line", cap_line,
            {64'h5A5A_A5A5_5A5A_A5A5, 64'h0F0F_0F0F_F0F0_F0F0,
             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
      check("rst_refill_windex", cap_idx, 3'd2);
      check("rst_refill_tag", cap_tag, 24'h00002F);

      // Randomized fills.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < NB; i++) begin
            beat_tab[i] = {$urandom, $urandom};
            gap_tab[i]  = (i == 0) ? 0 : int'($urandom_range(0, 3));
         end
         gsum = gap_tab[1] + gap_tab[2] + gap_tab[3];
         if ($urandom_range(0, 3) == 0) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            tick();
            pmem_resp = 1'b0;
         end
         do_fill($urandom, 1'($urandom), 1'($urandom), 1'($urandom));
         check("rand_latency", last_lat, 7 + gsum);
         check("rand_line", cap_line, tab_line());
      end

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
